// File: rtl/signed_adder_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | signed_adder_pkg: shared width, types and sign-extension helper     |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
package signed_adder_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef logic signed [DEFAULT_WIDTH-1:0] operand_t;
  typedef logic signed [DEFAULT_WIDTH:0]   sum_t;

  function automatic sum_t sign_ext(input operand_t v);
    return {v[DEFAULT_WIDTH-1], v};
  endfunction

endpackage
`default_nettype wire

// File: rtl/full_adder_cell.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | full_adder_cell: one-bit full adder, link of the ripple chain       |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic w_half;

  assign w_half = a ^ b;
  assign s      = w_half ^ cin;
  assign cout   = (a & b) | (cin & w_half);

endmodule
`default_nettype wire

// File: rtl/signed_adder_reg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | signed_adder_reg: registered full-precision two's-complement adder  |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module signed_adder_reg
  import signed_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [WIDTH-1:0] A,
  input  logic signed [WIDTH-1:0] B,
  output logic signed [WIDTH:0]   C
);

  logic [WIDTH:0]       w_a_ext;
  logic [WIDTH:0]       w_b_ext;
  logic [WIDTH:0]       w_sum;
  logic [WIDTH+1:0]     w_carry;
  logic                 w_carry_unused;
  logic signed [WIDTH:0] c_d;
  logic signed [WIDTH:0] c_q;

  assign w_a_ext    = {A[WIDTH-1], A};
  assign w_b_ext    = {B[WIDTH-1], B};
  assign w_carry[0] = 1'b0;

  for (genvar i = 0; i <= WIDTH; i++) begin : g_fa
    full_adder_cell u_fa (
      .a    (w_a_ext[i]),
      .b    (w_b_ext[i]),
      .cin  (w_carry[i]),
      .s    (w_sum[i]),
      .cout (w_carry[i+1])
    );
  end

  // Top carry carries no information once both operands are sign-extended.
  assign w_carry_unused = w_carry[WIDTH+1];

  assign c_d = w_sum;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      c_q <= '0;
    end else begin
      c_q <= c_d;
    end
  end

  assign C = c_q;

endmodule
`default_nettype wire

// File: tb/tb_signed_adder_reg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_signed_adder_reg: randomized + directed bench, arithmetic model  |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module tb_signed_adder_reg;

  logic              clk;
  logic              reset;
  logic signed [3:0] a4, b4;
  logic signed [4:0] c4;
  logic signed [7:0] a8, b8;
  logic signed [8:0] c8;

  int checks;
  int errors;
  int correct;

  signed_adder_reg #(.WIDTH(4)) u_dut4 (
    .clk   (clk),
    .reset (reset),
    .A     (a4),
    .B     (b4),
    .C     (c4)
  );

  signed_adder_reg #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .reset (reset),
    .A     (a8),
    .B     (b8),
    .C     (c8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [15:0] got,
                       input logic signed [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (%b) expected %0d", tag, got, got, exp);
    end else begin
      correct++;
    end
  endtask

  // Drive a pair before the edge, check the exact integer sum after it.
  task automatic step4(input string tag, input int a, input int b);
    @(negedge clk);
    a4 = 4'(a);
    b4 = 4'(b);
    @(posedge clk);
    #1;
    check(tag, c4, 16'(a + b));
  endtask

  task automatic step8(input string tag, input int a, input int b);
    @(negedge clk);
    a8 = 8'(a);
    b8 = 8'(b);
    @(posedge clk);
    #1;
    check(tag, c8, 16'(a + b));
  endtask

  initial begin
    int idx;
    checks  = 0;
    errors  = 0;
    correct = 0;

    reset = 1'b0;
    a4 = 4'sd1;
    b4 = 4'sd1;
    a8 = '0;
    b8 = '0;
    #1;
    check("rst_async", c4, 16'sd0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold", c4, 16'sd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rst_release", c4, 16'sd2);

    step4("ext_min", -8, -8);
    step4("ext_max", 7, 7);
    step4("ext_mix", -8, 7);
    step4("ext_zero", 0, 0);

    step4("lat_first", 3, 2);
    @(negedge clk);
    check("lat_hold", c4, 16'sd5);
    a4 = -4'sd5;
    b4 = -4'sd4;
    #2;
    check("lat_hold2", c4, 16'sd5);
    @(posedge clk);
    #1;
    check("lat_second", c4, -16'sd9);

    idx = 0;
    for (int a = -8; a <= 7; a++) begin
      for (int b = -8; b <= 7; b++) begin
        step4("sweep", a, b);
        if (idx == 100) begin
          #2;
          reset = 1'b0;
          #1;
          check("mid_rst", c4, 16'sd0);
          #1;
          reset = 1'b1;
        end
        idx++;
      end
    end

    for (int i = 0; i < 100; i++) begin
      step4("rand4", int'($urandom_range(15)) - 8, int'($urandom_range(15)) - 8);
    end

    step8("w8_min", -128, -128);
    step8("w8_max", 127, 127);
    for (int i = 0; i < 100; i++) begin
      step8("rand8", int'($urandom_range(255)) - 128, int'($urandom_range(255)) - 128);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/signed_adder_reg.md
# signed_adder_reg

Registered two's-complement adder producing a full-precision sum: two WIDTH-bit signed operands are added with sign extension and the WIDTH+1-bit result is captured in an output register. The block is a leaf datapath element used wherever a saturation-free, overflow-free signed sum is needed one clock after the operands are presented. The default configuration is 4-bit operands and a 5-bit result.

## Interface
- WIDTH, default 4: operand width in bits, ≥ 2.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset; forces C to 0.
- A  input  WIDTH  signed operand, two's complement.
- B  input  WIDTH  signed operand, two's complement.
- C  output  WIDTH+1  registered signed sum A + B, two's complement.

## Operation
- Sum computed at WIDTH+1 bits.
  - Both operands sign-extended by one bit (MSB replicated) before addition.
  - Result is exact for every operand pair: no overflow, no saturation, no wrap.
- Range for WIDTH=4:
  - Operands span -8..+7.
  - C spans -16..+14.
- Adder is a ripple-carry chain of WIDTH+1 full-adder cells:
  - Carry-in to bit 0 is 0.
  - Final carry-out is discarded; it is redundant given the sign extension.
- Register update on each rising clk edge while reset is high: C <= ext(A) + ext(B).
- No enable. The register loads every cycle.
- Operands are not registered; they only need to be stable for setup/hold around the capturing edge.
- Reset is asserted by driving reset low:
  - C goes to 0 immediately, with no clock required.
  - C stays 0 while reset is low, regardless of A, B and clock edges.
- Reset deassertion (reset rising):
  - Takes effect synchronously to clk; deassertion is synchronized externally.
  - The first rising edge with reset high loads the current A + B.
- Reset asserted mid-stream: the pending sum is lost and C reads 0. No other state exists.
- X/Z on A or B: propagates to C on the next edge. No checking is done.

## Timing
- Latency is 1 cycle: the value on A, B at rising edge N appears on C after edge N and holds until edge N+1.
- Throughput is one new sum per cycle.
- Combinational path runs A/B → ripple chain → C flop D-input. This path is the critical path and scales linearly with WIDTH.
- Reset-to-output is asynchronous and combinational through the flop reset pin.
- C is glitch-free between edges because it is driven directly by flops.

## Structure
- Shared package signed_adder_pkg holds:
  - Default WIDTH constant (4).
  - Helper function sign_ext(WIDTH→WIDTH+1).
  - Typedefs operand_t (logic signed [WIDTH-1:0]) and sum_t (logic signed [WIDTH:0]) for the default width.
- One sub-module, full_adder_cell:
  - Inputs a, b, cin.
  - Outputs s, cout.
  - Instantiated WIDTH+1 times in a generate loop.
- Top level contains:
  - Sign extension of A and B.
  - The generate chain.
  - The output register with its asynchronous active-low reset.
- No behavioural "+" operator in the datapath: the chain is explicit so that the structure can be inspected and timed.

## Test plan
- Reset: drive reset low with A=1, B=1 → C=0 before any clock edge. C stays 0 across edges until reset goes high; the first edge after release gives C=2.
- Exhaustive sweep (WIDTH=4): all 256 pairs of A, B in -8..+7, one pair per cycle → C equals the exact sum one cycle later.
  - Compare with 4-state inequality.
  - Zero mismatches required; the bench also counts correct results.
- Extremes:
  - A=-8, B=-8 → C=-16 (5'b10000).
  - A=7, B=7 → C=14 (5'b01110).
  - A=-8, B=7 → C=-1 (5'b11111).
  - A=0, B=0 → C=0.
- Latency check: A=3, B=2 at edge N, then A=-5, B=-4 at edge N+1 → C=5 during cycle N..N+1 and C=-9 after edge N+1.
- Mid-stream reset: during the sweep, pulse reset low between clock edges → C=0 immediately. After release, the next edge loads the current pair, and the sweep continues with no mismatches.
- Parameter check: WIDTH=8 with A=-128, B=-128 → C=-256; with A=127, B=127 → C=254.
